jtframe_cenwait_mc: RTL

Multi-channel clock-enable wait generator for CPU cores (Z80-class) fetching from SDRAM-backed ROMs and shared devices. Gates the CPU clock enable while any selected ROM channel has no valid data or any shared device is busy. Optionally recovers the suppressed enable pulses afterwards so average CPU speed tracks the nominal rate. It sits between the system cen divider and the CPU wrapper's `cen` input, replacing the single-ROM wait block.

---
 rtl/jtframe_cenwait_mc_if.sv | 22 ++
 rtl/jtframe_cenwait_mc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/jtframe_cenwait_mc_if.sv
// CPU-side bus signals that decide whether the CPU clock enable must wait:
// memory/I-O request strobes, bus acknowledge, per-channel ROM select and
// data-valid flags, and per-device busy flags.
interface jtframe_cenwait_mc_if #(
  parameter int ROMCNT = 2,
  parameter int DEVCNT = 1
);
  logic              mreq_n;
  logic              iorq_n;
  logic              busak_n;
  logic [ROMCNT-1:0] rom_cs;
  logic [ROMCNT-1:0] rom_ok;
  logic [DEVCNT-1:0] dev_busy;

  modport master (
    output mreq_n, iorq_n, busak_n, rom_cs, rom_ok, dev_busy
  );

  modport slave (
    input mreq_n, iorq_n, busak_n, rom_cs, rom_ok, dev_busy
  );
endinterface

// File: rtl/jtframe_cenwait_mc.sv
// Multi-channel clock-enable wait generator. Holds the CPU clock enable low
// while a selected ROM channel has no valid data or a shared device is busy,
// and optionally replays the swallowed enable pulses once the CPU may run.
module jtframe_cenwait_mc #(
  parameter int ROMCNT   = 2,
  parameter int DEVCNT   = 1,
  parameter int RECOVERY = 1,
  parameter int CNTW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen_in,
  output logic            cen_out,
  output logic            gate,
  output logic [CNTW-1:0] lost,
  jtframe_cenwait_mc_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ROMWAIT = 2'd1,
    DEVWAIT = 2'd2
  } state_t;

  localparam logic            REC_EN   = (RECOVERY != 0);
  localparam logic [CNTW-1:0] LOST_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] LOST_ONE = CNTW'(1);

  state_t            state;
  state_t            state_nx;
  logic [ROMCNT-1:0] cs_l;
  logic [ROMCNT-1:0] cs_rise;
  logic              cen_out_l;
  logic              pending;
  logic              rom_bad;
  logic              rom_wait;
  logic              dev_wait;
  logic              rec;

  // A freshly selected channel may still show rom_ok from the previous
  // access, so its first cycle counts as not ready.
  assign cs_rise  = bus.rom_cs & ~cs_l;
  assign pending  = |(bus.rom_cs & (~bus.rom_ok | cs_rise));
  assign rom_bad  = |(bus.rom_cs & ~bus.rom_ok);
  assign rom_wait = ~bus.mreq_n & bus.busak_n & pending;
  assign dev_wait = (~bus.mreq_n | ~bus.iorq_n) & bus.busak_n & (|bus.dev_busy);

  // The CPU keeps its clock during reset; otherwise it only runs when idle
  // and no new wait condition shows up in this very cycle.
  assign gate = rst_n ? ((state == RUN) & ~rom_wait & ~dev_wait) : 1'b1;

  // Replay a lost pulse only into a free slot: no nominal pulse now and no
  // pulse issued in the previous cycle.
  assign rec = REC_EN & gate & ~cen_in & (lost != {CNTW{1'b0}}) & ~cen_out_l;

  assign cen_out = (cen_in & gate) | rec;

  // State register for the wait FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: ROM waits win over device waits, and a ROM wait must
  // pass through RUN before a device wait can start.
  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (rom_wait) begin
          state_nx = ROMWAIT;
        end else if (dev_wait) begin
          state_nx = DEVWAIT;
        end else begin
          state_nx = RUN;
        end
      end
      ROMWAIT: begin
        if (bus.mreq_n | ~bus.busak_n | ~rom_bad) begin
          state_nx = RUN;
        end else begin
          state_nx = ROMWAIT;
        end
      end
      DEVWAIT: begin
        if (~(|bus.dev_busy) | (bus.mreq_n & bus.iorq_n) | ~bus.busak_n) begin
          state_nx = RUN;
        end else begin
          state_nx = DEVWAIT;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  // Remember the previous select and issued enable for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_l      <= {ROMCNT{1'b0}};
      cen_out_l <= 1'b0;
    end else begin
      cs_l      <= bus.rom_cs;
      cen_out_l <= cen_out;
    end
  end

  // Saturating count of swallowed enable pulses, drained by replays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost <= {CNTW{1'b0}};
    end else if (!REC_EN) begin
      lost <= {CNTW{1'b0}};
    end else if (cen_in & ~gate) begin
      if (lost != LOST_MAX) begin
        lost <= lost + LOST_ONE;
      end
    end else if (rec) begin
      lost <= lost - LOST_ONE;
    end
  end

endmodule
